// File: rtl/yolo_conv_pkg.sv
// Shared constants, FSM states and saturation helper for the 3x3 tap accumulator.
// Optional build macro: RELU_EN (clamps negative results to zero in the top).
package yolo_conv_pkg;

    localparam int NUM_TAPS = 9;
    localparam logic [3:0] LAST_TAP = 4'd8;
    localparam int SAT_W = 32;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    // Clamp a wide signed value into a signed w-bit range.
    function automatic logic signed [SAT_W-1:0] sat(
        input logic signed [SAT_W-1:0] v,
        input int w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (v > hi) return hi;
        else if (v < lo) return lo;
        else return v;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed pixel x weight multiply with load-or-accumulate select.
// Purely combinational; the caller owns the accumulator register.
module conv_mac_unit
    import yolo_conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 4
) (
    input  logic signed [DATA_W-1:0] pixel,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic                     load,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] prod;

    assign p_ext = ACC_W'(pixel);
    assign w_ext = ACC_W'(weight);
    assign prod  = p_ext * w_ext;
    assign sum   = load ? prod : acc_in + prod;

endmodule

// File: rtl/conv3x3_tap_accumulator.sv
// Accumulates nine in-order (pixel, weight) taps into one saturated result.
// Optional build macro: RELU_EN (negative results are output as zero).
module conv3x3_tap_accumulator
    import yolo_conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 4,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tap_valid,
    output logic                     tap_ready,
    input  logic [3:0]               tap_idx,
    input  logic signed [DATA_W-1:0] pixel,
    input  logic signed [DATA_W-1:0] weight,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     seq_err
);

    state_t state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [OUT_W-1:0] res;
    logic [3:0] exp_idx, exp_nxt;
    logic accept, idx_zero, hit, last;
    logic mac_load, done, err;

    assign tap_ready = !out_valid || out_ready;
    assign accept    = tap_valid && tap_ready;
    assign idx_zero  = (tap_idx == 4'd0);
    assign hit       = (tap_idx == exp_idx);
    assign last      = (exp_idx == LAST_TAP);
    assign mac_load  = (state == IDLE) || idx_zero;

    conv_mac_unit #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .pixel (pixel),
        .weight(weight),
        .acc_in(acc),
        .load  (mac_load),
        .sum   (mac_sum)
    );

    // Window result: saturate, then optionally rectify.
    always_comb begin
        res = OUT_W'(sat(SAT_W'(mac_sum), OUT_W));
`ifdef RELU_EN
        if (res < 0) res = '0;
`else
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state, sequence check and accumulator update.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        exp_nxt   = exp_idx;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (idx_zero) begin
                        acc_nxt   = mac_sum;
                        exp_nxt   = 4'd1;
                        state_nxt = ACCUM;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    unique case (1'b1)
                        hit && !last: begin
                            acc_nxt = mac_sum;
                            exp_nxt = exp_idx + 4'd1;
                        end
                        hit && last: begin
                            done      = 1'b1;
                            acc_nxt   = '0;
                            exp_nxt   = '0;
                            state_nxt = IDLE;
                        end
                        !hit && idx_zero: begin
                            err     = 1'b1;
                            acc_nxt = mac_sum;
                            exp_nxt = 4'd1;
                        end
                        !hit && !idx_zero: begin
                            err       = 1'b1;
                            acc_nxt   = '0;
                            exp_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator and expected-index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            exp_idx <= '0;
        end else begin
            acc     <= acc_nxt;
            exp_idx <= exp_nxt;
        end
    end

    // Output holding register and error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            seq_err   <= 1'b0;
        end else begin
            if (done) begin
                out_valid <= 1'b1;
                out_data  <= res;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            seq_err <= err;
        end
    end

endmodule

// File: tb/tb_conv3x3_tap_accumulator.sv
// Randomized and directed bench for conv3x3_tap_accumulator.
// Expected results come from a window-level sum-and-clamp model.
module tb_conv3x3_tap_accumulator;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic tap_valid;
    logic tap_ready;
    logic [3:0] tap_idx;
    logic signed [DATA_W-1:0] pixel;
    logic signed [DATA_W-1:0] weight;
    logic out_valid;
    logic out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic seq_err;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int exp_q[$];
    bit rand_ready = 0;
    int pix[9];
    int wgt[9];

    always #5 clk = ~clk;

    conv3x3_tap_accumulator dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tap_valid(tap_valid),
        .tap_ready(tap_ready),
        .tap_idx  (tap_idx),
        .pixel    (pixel),
        .weight   (weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .seq_err  (seq_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_window(input int n);
        longint s = 0;
        longint hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        longint lo = -hi - 1;
        for (int i = 0; i < n; i++) s += longint'(pix[i]) * longint'(wgt[i]);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`ifdef RELU_EN
        if (s < 0) s = 0;
`else
`endif
        return int'(s);
    endfunction

    // Scoreboard: a pop happens at the next edge when both are high here.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (seq_err) err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) check("out_data", int'(out_data), exp_q.pop_front());
                else check("spurious_out", 1, 0);
            end
        end
    end

    // Random backpressure, changed just after each edge.
    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_tap(input int idx, input int p, input int w);
        int budget = 200;
        tap_valid = 1'b1;
        tap_idx   = 4'(idx);
        pixel     = DATA_W'(p);
        weight    = DATA_W'(w);
        forever begin
            @(negedge clk);
            if (tap_ready) break;
            budget--;
            if (budget == 0) begin
                check("tap_timeout", 0, 1);
                break;
            end
        end
        step();
        tap_valid = 1'b0;
    endtask

    task automatic send_window(input int gap_max);
        exp_q.push_back(ref_window(9));
        for (int i = 0; i < 9; i++) begin
            send_tap(i, pix[i], wgt[i]);
            if (gap_max > 0) repeat ($urandom_range(gap_max)) step();
        end
    endtask

    task automatic fill(input int p, input int w);
        for (int i = 0; i < 9; i++) begin
            pix[i] = p;
            wgt[i] = w;
        end
    endtask

    initial begin
        int held;
        int budget;
        int err_exp = 0;
        reset_n   = 1'b0;
        tap_valid = 1'b0;
        tap_idx   = '0;
        pixel     = '0;
        weight    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_seq_err", int'(seq_err), 0);
        check("rst_tap_ready", int'(tap_ready), 1);
        step();
        reset_n = 1'b1;
        step();

        // 1: pixels 1..9, weights 1, back to back
        for (int i = 0; i < 9; i++) begin
            pix[i] = i + 1;
            wgt[i] = 1;
        end
        check("t1_model", ref_window(9), 45);
        exp_q.push_back(45);
        for (int i = 0; i < 9; i++) begin
            send_tap(i, pix[i], wgt[i]);
            if (i == 7) check("t1_valid_early", int'(out_valid), 0);
        end
        @(negedge clk);
        check("t1_latency", int'(out_valid), 1);
        step();

        // 2: negative saturation
        fill(-128, 127);
        send_window(0);
        // positive saturation
        fill(-128, -128);
        send_window(0);
        step();

        // 3: backpressure hold, then pop and accept together
        out_ready = 1'b0;
        fill(100, -3);
        send_window(0);
        held = exp_q[0];
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_valid", int'(out_valid), 1);
            check("t3_hold_data", int'(out_data), held);
            check("t3_ready_low", int'(tap_ready), 0);
        end
        fill(7, 9);
        exp_q.push_back(ref_window(9));
        tap_valid = 1'b1;
        tap_idx   = 4'd0;
        pixel     = 8'sd7;
        weight    = 8'sd9;
        step();
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_up", int'(tap_ready), 1);
        step();
        tap_valid = 1'b0;
        check("t3_popped", int'(out_valid), 0);
        for (int i = 1; i < 9; i++) send_tap(i, pix[i], wgt[i]);
        step();

        // 4: out-of-order tap, then a clean window
        send_tap(0, 5, 5);
        send_tap(1, 5, 5);
        send_tap(2, 5, 5);
        send_tap(5, 5, 5);
        err_exp++;
        @(negedge clk);
        check("t4_seq_err", int'(seq_err), 1);
        check("t4_no_out", int'(out_valid), 0);
        step();
        fill(2, 3);
        check("t4_model", ref_window(9), 54);
        send_window(0);
        repeat (2) step();

        // 5: reset mid-window
        for (int i = 0; i < 5; i++) send_tap(i, 11, 13);
        reset_n = 1'b0;
        #1;
        check("t5_rst_valid", int'(out_valid), 0);
        check("t5_rst_data", int'(out_data), 0);
        check("t5_rst_err", int'(seq_err), 0);
        step();
        reset_n = 1'b1;
        step();
        fill(-4, 6);
        send_window(0);
        repeat (2) step();

        // 6: random windows with gaps and backpressure
        rand_ready = 1;
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 9; i++) begin
                if ($urandom_range(9) == 0) begin
                    pix[i] = -128;
                    wgt[i] = ($urandom_range(1) != 0) ? 127 : -128;
                end else begin
                    pix[i] = int'($urandom_range(255)) - 128;
                    wgt[i] = int'($urandom_range(255)) - 128;
                end
            end
            send_window(($urandom_range(1) != 0) ? 2 : 0);
        end
        rand_ready = 0;
        step();
        out_ready = 1'b1;
        budget = 50;
        while (exp_q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        check("drain_left", exp_q.size(), 0);
        check("seq_err_count", err_seen, err_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
